// File: rtl/snax_acc_csr_manager.sv
// -----------------------------------------------------------------------------
// snax_acc_csr_manager
//
// CSR-side manager for a SNAX accelerator shell. The core writes staged
// read-write registers through a valid/ready request port. A write to the
// LAUNCH address snapshots the staged set and offers it to the accelerator
// through a valid/ready commit handshake. Reads return staged registers,
// the accelerator's read-only registers, the launch status or a commit counter.
//
// Address map (register index):
//   0 .. RegRWCount-1                     staged read-write registers
//   RegRWCount .. RegRWCount+RegROCount-1 accelerator read-only registers
//   LAUNCH = RegRWCount+RegROCount        write: commit, read: {0.., valid}
//   COUNT  = LAUNCH+1                     read: number of commits (wrapping)
//   anything above COUNT                  out of range (reads 0, writes ignored)
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   csr_req_*              core request (addr, data, write, valid/ready)
//   csr_rsp_*              read response (data, valid/ready)
//   acc_reg_set_o/_valid_o/_ready_i  committed snapshot to the accelerator
//   acc_reg_ro_set_i       accelerator read-only values, register j in slice j
// -----------------------------------------------------------------------------
module snax_acc_csr_manager #(
    parameter int RegRWCount   = 2,
    parameter int RegROCount   = 2,
    parameter int RegDataWidth = 32,
    parameter int RegAddrWidth = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [RegAddrWidth-1:0]            csr_req_addr_i,
    input  logic [RegDataWidth-1:0]            csr_req_data_i,
    input  logic                               csr_req_write_i,
    input  logic                               csr_req_valid_i,
    output logic                               csr_req_ready_o,
    output logic [RegDataWidth-1:0]            csr_rsp_data_o,
    output logic                               csr_rsp_valid_o,
    input  logic                               csr_rsp_ready_i,
    output logic [RegRWCount*RegDataWidth-1:0] acc_reg_set_o,
    output logic                               acc_reg_set_valid_o,
    input  logic                               acc_reg_set_ready_i,
    input  logic [RegROCount*RegDataWidth-1:0] acc_reg_ro_set_i
);

    localparam int LaunchAddr = RegRWCount + RegROCount;
    localparam int CountAddr  = LaunchAddr + 1;
    // Bits needed to decode the whole map; anything set above them is out of range.
    localparam int DecW       = $clog2(CountAddr + 1);

    logic [RegDataWidth-1:0] staged [RegRWCount];
    logic [RegDataWidth-1:0] commit_cnt;
    logic [RegDataWidth-1:0] rd_data;

    logic [DecW-1:0] addr_lo;
    logic            addr_upper_zero;
    logic            is_launch;
    logic            is_count;
    logic            rsp_stall;
    logic            commit_stall;
    logic            req_fire;
    logic            wr_fire;
    logic            rd_fire;
    logic            launch_fire;

    assign addr_lo         = csr_req_addr_i[DecW-1:0];
    assign addr_upper_zero = (csr_req_addr_i[RegAddrWidth-1:DecW] == '0);
    assign is_launch       = addr_upper_zero && (addr_lo == DecW'(LaunchAddr));
    assign is_count        = addr_upper_zero && (addr_lo == DecW'(CountAddr));

    // A held response blocks every request (reads and writes alike) so the
    // request/response ordering stays trivially in order. A LAUNCH only waits
    // while the previous commit is still unaccepted; if the accelerator takes
    // it this cycle the new snapshot follows without a bubble.
    assign rsp_stall    = csr_rsp_valid_o && !csr_rsp_ready_i;
    assign commit_stall = csr_req_write_i && is_launch &&
                          acc_reg_set_valid_o && !acc_reg_set_ready_i;

    assign csr_req_ready_o = !rsp_stall && !commit_stall;
    assign req_fire        = csr_req_valid_i && csr_req_ready_o;
    assign wr_fire         = req_fire && csr_req_write_i;
    assign rd_fire         = req_fire && !csr_req_write_i;
    assign launch_fire     = wr_fire && is_launch;

    // Read data selection; out-of-range addresses fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < RegRWCount; k++) begin
            if (addr_upper_zero && (addr_lo == DecW'(k))) begin
                rd_data = staged[k];
            end
        end
        for (int j = 0; j < RegROCount; j++) begin
            if (addr_upper_zero && (addr_lo == DecW'(RegRWCount + j))) begin
                rd_data = acc_reg_ro_set_i[j*RegDataWidth +: RegDataWidth];
            end
        end
        if (is_launch) begin
            rd_data = {{(RegDataWidth-1){1'b0}}, acc_reg_set_valid_o};
        end
        if (is_count) begin
            rd_data = commit_cnt;
        end
    end

    // Staged read-write registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < RegRWCount; k++) begin
                staged[k] <= '0;
            end
        end else if (wr_fire) begin
            for (int k = 0; k < RegRWCount; k++) begin
                if (addr_upper_zero && (addr_lo == DecW'(k))) begin
                    staged[k] <= csr_req_data_i;
                end
            end
        end
    end

    // Commit snapshot and handshake; a new launch wins over the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_reg_set_o       <= '0;
            acc_reg_set_valid_o <= 1'b0;
            commit_cnt          <= '0;
        end else if (launch_fire) begin
            for (int k = 0; k < RegRWCount; k++) begin
                acc_reg_set_o[k*RegDataWidth +: RegDataWidth] <= staged[k];
            end
            acc_reg_set_valid_o <= 1'b1;
            commit_cnt          <= commit_cnt + 1'b1;
        end else if (acc_reg_set_ready_i) begin
            acc_reg_set_valid_o <= 1'b0;
        end
    end

    // Read response register; data holds until the next accepted read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_rsp_valid_o <= 1'b0;
            csr_rsp_data_o  <= '0;
        end else if (rd_fire) begin
            csr_rsp_valid_o <= 1'b1;
            csr_rsp_data_o  <= rd_data;
        end else if (csr_rsp_ready_i) begin
            csr_rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snax_acc_csr_manager.sv
module tb_snax_acc_csr_manager;

    localparam int RW     = 2;
    localparam int RO     = 2;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int LAUNCH = RW + RO;
    localparam int COUNT  = LAUNCH + 1;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_data;
    logic             req_write;
    logic             req_valid;
    logic             req_ready;
    logic [DW-1:0]    rsp_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RW*DW-1:0] set_o;
    logic             set_valid;
    logic             set_ready;
    logic [RO*DW-1:0] ro_set;

    snax_acc_csr_manager #(
        .RegRWCount  (RW),
        .RegROCount  (RO),
        .RegDataWidth(DW),
        .RegAddrWidth(AW)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .csr_req_addr_i     (req_addr),
        .csr_req_data_i     (req_data),
        .csr_req_write_i    (req_write),
        .csr_req_valid_i    (req_valid),
        .csr_req_ready_o    (req_ready),
        .csr_rsp_data_o     (rsp_data),
        .csr_rsp_valid_o    (rsp_valid),
        .csr_rsp_ready_i    (rsp_ready),
        .acc_reg_set_o      (set_o),
        .acc_reg_set_valid_o(set_valid),
        .acc_reg_set_ready_i(set_ready),
        .acc_reg_ro_set_i   (ro_set)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state only.
    logic [DW-1:0]    m_staged [RW];
    logic [RW*DW-1:0] m_set;
    logic             m_valid;
    logic [DW-1:0]    m_cnt;
    logic             m_rsp_valid;
    logic [DW-1:0]    m_rsp_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a < RW)          return m_staged[a];
        if (a < RW + RO)     return ro_set[(a - RW)*DW +: DW];
        if (a == LAUNCH)     return {{(DW-1){1'b0}}, m_valid};
        if (a == COUNT)      return m_cnt;
        return '0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < RW; k++) m_staged[k] = '0;
        m_set       = '0;
        m_valid     = 1'b0;
        m_cnt       = '0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
    endtask

    task automatic check_outputs();
        check("set_valid", 64'(set_valid), 64'(m_valid));
        check("set_data",  64'(set_o),     64'(m_set));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("rsp_data",  64'(rsp_data),  64'(m_rsp_data));
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                        input logic v, input logic rr, input logic sr);
        logic          exp_ready;
        logic          acc;
        logic [DW-1:0] rd;
        req_addr  = a;
        req_data  = d;
        req_write = w;
        req_valid = v;
        rsp_ready = rr;
        set_ready = sr;
        #1;
        exp_ready = !(m_rsp_valid && !rr) && !(w && (a == LAUNCH) && m_valid && !sr);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        acc = v && exp_ready;
        rd  = model_read(a);
        @(posedge clk);
        if (acc && w && (a == LAUNCH)) begin
            for (int k = 0; k < RW; k++) m_set[k*DW +: DW] = m_staged[k];
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
        end else begin
            if (acc && w && (a < RW)) m_staged[a] = d;
            if (sr) m_valid = 1'b0;
        end
        if (acc && !w) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = rd;
        end else if (rr) begin
            m_rsp_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic rr, input logic sr);
        step('0, '0, 1'b0, 1'b0, rr, sr);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        req_valid = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        model_clear();
        check_outputs();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] held;
        rst_ni    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_write = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        set_ready = 1'b0;
        ro_set    = '0;
        model_clear();
        #12;
        check_outputs();
        check("req_ready_rst", 64'(req_ready), 64'(1));
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // 1: stage, launch, hold commit, release
        step(0, 32'hA5, 1, 1, 1, 0);
        step(1, 32'h3C, 1, 1, 1, 0);
        step(LAUNCH, 32'hFFFF_FFFF, 1, 1, 1, 0);
        check("t1_valid", 64'(set_valid), 64'(1));
        check("t1_snap", 64'(set_o), {32'h3C, 32'hA5});
        for (int i = 0; i < 5; i++) idle(1, 0);
        check("t1_hold", 64'(set_o), {32'h3C, 32'hA5});
        idle(1, 1);
        check("t1_clear", 64'(set_valid), 64'(0));

        // 2: read-only registers, back to back
        ro_set = {32'h1234, 32'hBEEF};
        step(2, 0, 0, 1, 1, 0);
        check("t2_ro0", 64'(rsp_data), 64'h BEEF);
        step(3, 0, 0, 1, 1, 0);
        check("t2_ro1", 64'(rsp_data), 64'h1234);
        idle(1, 0);

        // 3: staged write while pending, launch stalls then goes back to back
        step(LAUNCH, 0, 1, 1, 1, 0);
        step(0, 32'h77, 1, 1, 1, 0);
        check("t3_snap_kept", 64'(set_o[31:0]), 64'hA5);
        for (int i = 0; i < 3; i++) step(LAUNCH, 0, 1, 1, 1, 0);
        step(LAUNCH, 0, 1, 1, 1, 1);
        check("t3_valid_kept", 64'(set_valid), 64'(1));
        check("t3_new_snap", 64'(set_o[31:0]), 64'h77);
        idle(1, 1);

        // 4: response backpressure stalls the next request
        step(0, 0, 0, 1, 0, 0);
        held = rsp_data;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
        check("t4_held", 64'(rsp_data), 64'(held));
        step(1, 0, 0, 1, 1, 0);
        check("t4_second", 64'(rsp_data), 64'h3C);
        idle(1, 0);

        // 5: commit counter and out-of-range accesses
        do_reset();
        for (int i = 0; i < 3; i++) step(LAUNCH, 0, 1, 1, 1, 1);
        idle(1, 1);
        step(COUNT, 0, 0, 1, 1, 0);
        check("t5_count", 64'(rsp_data), 64'(3));
        step(32'hFF, 0, 0, 1, 1, 0);
        check("t5_oor_read", 64'(rsp_data), 64'(0));
        step(32'hFF, 32'hDEAD, 1, 1, 1, 0);
        step(32'h100, 32'hBEEF, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        check("t5_staged1", 64'(rsp_data), 64'(0));

        // 6: reset with a commit and a response both pending
        step(0, 32'h55, 1, 1, 1, 0);
        step(LAUNCH, 0, 1, 1, 1, 0);
        step(COUNT, 0, 0, 1, 0, 0);
        do_reset();
        idle(1, 0);
        step(LAUNCH, 0, 0, 1, 1, 0);
        check("t6_launch_rd", 64'(rsp_data), 64'(0));
        step(0, 0, 0, 1, 1, 0);
        check("t6_staged0", 64'(rsp_data), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ro_set = {$urandom, $urandom};
            ra = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ra = ra | (AW'(1) << $urandom_range(3, 31));
            step(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end
        idle(1, 1);
        step(COUNT, 0, 0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snax_acc_csr_manager.md
Name: snax_acc_csr_manager

Overview:
- CSR-side counterpart of the SNAX accelerator shell's CSR port.
- Accepts core CSR read/write requests and holds staged read-write registers.
- On a write to the launch address, snapshots the staged registers and presents them to the accelerator shell through a valid/ready commit handshake.
- Serves reads of the accelerator's read-only registers, the launch status and a commit counter back to the core.

Parameters:
- RegRWCount, 2, number of read-write (staged) registers; addresses 0..RegRWCount-1.
- RegROCount, 2, number of read-only registers; addresses RegRWCount..RegRWCount+RegROCount-1.
- RegDataWidth, 32, CSR data width.
- RegAddrWidth, 32, request address width; only the low bits needed to decode the map are compared, and any nonzero upper bit means out of range.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_req_addr_i  in  RegAddrWidth  request register index
- csr_req_data_i  in  RegDataWidth  write data
- csr_req_write_i  in  1  1=write, 0=read
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request accepted
- csr_rsp_data_o  out  RegDataWidth  read data
- csr_rsp_valid_o  out  1  read response valid
- csr_rsp_ready_i  in  1  read response consumed
- acc_reg_set_o  out  RegRWCount*RegDataWidth  committed register snapshot; register k occupies slice k
- acc_reg_set_valid_o  out  1  commit valid
- acc_reg_set_ready_i  in  1  accelerator accepts commit
- acc_reg_ro_set_i  in  RegROCount*RegDataWidth  accelerator read-only values

Behaviour:
- Address map: LAUNCH = RegRWCount+RegROCount; COUNT = LAUNCH+1. Above COUNT is out of range.
- Reset values: all staged regs 0, acc_reg_set_o 0, acc_reg_set_valid_o 0, csr_rsp_valid_o 0, csr_rsp_data_o 0, commit counter 0.
- Accept: a request is accepted when csr_req_valid_i and csr_req_ready_o are both high in the same cycle.
- csr_req_ready_o (combinational) is low when either:
  - a response is held (csr_rsp_valid_o=1 and csr_rsp_ready_i=0), or
  - the request is a write to LAUNCH while acc_reg_set_valid_o=1 and acc_reg_set_ready_i=0.
  - It is high otherwise, including after reset.
- Write to RW reg k: staged[k] updates at the next clock edge. There is no response, and acc_reg_set_o is not affected.
- Write to RO address or COUNT: ignored, no response.
- Write to LAUNCH (data ignored), at the next edge:
  - acc_reg_set_o <= staged;
  - acc_reg_set_valid_o <= 1;
  - commit counter += 1, wrapping at 2^RegDataWidth.
  - Latency: accepted in cycle N, valid high in cycle N+1.
- Commit handshake:
  - acc_reg_set_valid_o holds, and acc_reg_set_o is stable, until acc_reg_set_ready_i=1; valid clears at that edge.
  - If a new LAUNCH is accepted in that same cycle, valid stays 1 and acc_reg_set_o loads the new snapshot, so back-to-back commits have no bubble.
- Staged writes while a commit is pending are allowed and do not disturb acc_reg_set_o.
- Reads (one cycle latency): accepted in cycle N, csr_rsp_valid_o=1 with data in cycle N+1, held stable until csr_rsp_ready_i. Read data by address:
  - RW k: staged[k].
  - RO j: acc_reg_ro_set_i slice j, sampled in the accept cycle.
  - LAUNCH: {0..., acc_reg_set_valid_o}.
  - COUNT: commit counter.
  - Out of range: 0.
- A new read may be accepted in the same cycle the previous response is consumed (full throughput).
- Out-of-range write: ignored, no response.
- Reset mid-operation: all state returns to reset values asynchronously. A pending commit is dropped, and no valid is asserted after deassertion until a new LAUNCH.

Test Plan:
1. Reset, then write addr0=0xA5, addr1=0x3C, then write LAUNCH → next cycle valid=1 with slice0=0xA5, slice1=0x3C. Hold ready=0 for 5 cycles → valid and data stable. Ready=1 → valid=0 the cycle after.
2. acc_reg_ro_set_i={0x1234,0xBEEF} (slice1=0x1234, slice0=0xBEEF). Read addr2 then addr3 with rsp_ready=1 → responses 0xBEEF then 0x1234 on consecutive cycles, each one cycle after accept.
3. Commit pending (ready=0): write addr0=0x77 → accepted, acc_reg_set_o unchanged. Write LAUNCH → req_ready=0 until ready=1. In that same cycle it is accepted, valid stays 1 and slice0=0x77.
4. Read addr0 with rsp_ready=0 for 3 cycles → rsp_valid held with data stable, and a second request is stalled (req_ready=0). Raise rsp_ready → second request accepted the same cycle.
5. Issue 3 LAUNCH commits, then read COUNT → 3. Read addr 0xFF → 0. Write addr 0xFF → no staged reg changes.
6. Assert rst_ni=0 while valid=1 and a response is pending → valid, rsp_valid, counter and staged regs all 0 immediately. After release, read LAUNCH → 0.
